// File: rtl/median_frame_ctrl.sv
// Frame sequencer around the 3x3 median stage: admits one frame, appends flush
// beats to drain the line buffers, then re-emits an aligned, tagged pixel stream.
module median_frame_ctrl #(
  parameter int U_COL = 1280,
  parameter int U_ROW = 720,
  parameter int SKIP  = U_COL + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        border_zero,
  input  logic        in_de,
  input  logic [7:0]  in_data,
  output logic        filt_de,
  output logic [7:0]  filt_data,
  input  logic        filt_out_de,
  input  logic [7:0]  filt_out_data,
  output logic        out_de,
  output logic [7:0]  out_data,
  output logic [10:0] out_x,
  output logic [9:0]  out_y,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_border,
  output logic        busy,
  output logic        err_overrun
);

  localparam int TOTAL = U_COL * U_ROW;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int SK_W  = $clog2(SKIP + 1);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [SK_W-1:0]  SKIP_C  = SK_W'(SKIP);
  localparam logic [10:0]      X_LAST  = 11'(U_COL - 1);
  localparam logic [9:0]       Y_LAST  = 10'(U_ROW - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DRAIN} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [SK_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [SK_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [10:0]      col_q, col_d;
  logic [9:0]       row_q, row_d;
  logic             bz_q, bz_d;
  logic             err_q, err_d;
  logic             filt_de_q, filt_de_d;
  logic [7:0]       filt_data_q, filt_data_d;
  logic             out_de_q, out_de_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [10:0]      out_x_q, out_x_d;
  logic [9:0]       out_y_q, out_y_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic             out_border_q, out_border_d;
  logic             pix_border;

  function automatic logic is_border(input logic [10:0] x, input logic [9:0] y);
    return (x == 11'd0) || (x == X_LAST) || (y == 10'd0) || (y == Y_LAST);
  endfunction

  function automatic logic [7:0] border_pix(input logic bz, input logic brd,
                                            input logic [7:0] d);
    return (bz && brd) ? 8'd0 : d;
  endfunction

  assign pix_border = is_border(col_q, row_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACTIVE;
      S_ACTIVE: if (in_de && ((in_cnt_q + CNT_W'(1)) == TOTAL_C)) state_d = S_FLUSH;
      S_FLUSH:  if ((flush_cnt_q + SK_W'(1)) == SKIP_C) state_d = S_DRAIN;
      S_DRAIN:  if (out_cnt_q == TOTAL_C) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    col_d        = col_q;
    row_d        = row_q;
    bz_d         = bz_q;
    err_d        = err_q;
    filt_de_d    = 1'b0;
    filt_data_d  = filt_data_q;
    out_de_d     = 1'b0;
    out_data_d   = out_data_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_sof_d    = 1'b0;
    out_eof_d    = 1'b0;
    out_border_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bz_d        = border_zero;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          flush_cnt_d = '0;
          beat_cnt_d  = '0;
          col_d       = '0;
          row_d       = '0;
          err_d       = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (in_de) begin
          filt_de_d   = 1'b1;
          filt_data_d = in_data;
          in_cnt_d    = in_cnt_q + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        filt_de_d   = 1'b1;
        filt_data_d = 8'd0;
        flush_cnt_d = flush_cnt_q + SK_W'(1);
        if (in_de) err_d = 1'b1;
      end
      S_DRAIN: begin
        if (in_de) err_d = 1'b1;
      end
      default: ;
    endcase

    // Leading beats are the line-buffer fill; only later beats map to pixels.
    if (busy && filt_out_de) begin
      if (beat_cnt_q != SKIP_C) begin
        beat_cnt_d = beat_cnt_q + SK_W'(1);
      end else if (out_cnt_q != TOTAL_C) begin
        out_de_d     = 1'b1;
        out_data_d   = border_pix(bz_q, pix_border, filt_out_data);
        out_x_d      = col_q;
        out_y_d      = row_q;
        out_sof_d    = (col_q == 11'd0) && (row_q == 10'd0);
        out_eof_d    = (col_q == X_LAST) && (row_q == Y_LAST);
        out_border_d = pix_border;
        out_cnt_d    = out_cnt_q + CNT_W'(1);
        if (col_q == X_LAST) begin
          col_d = '0;
          row_d = row_q + 10'd1;
        end else begin
          col_d = col_q + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      col_q        <= '0;
      row_q        <= '0;
      bz_q         <= 1'b0;
      err_q        <= 1'b0;
      filt_de_q    <= 1'b0;
      filt_data_q  <= '0;
      out_de_q     <= 1'b0;
      out_data_q   <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_border_q <= 1'b0;
    end else begin
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      bz_q         <= bz_d;
      err_q        <= err_d;
      filt_de_q    <= filt_de_d;
      filt_data_q  <= filt_data_d;
      out_de_q     <= out_de_d;
      out_data_q   <= out_data_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
      out_border_q <= out_border_d;
    end
  end

  assign filt_de     = filt_de_q;
  assign filt_data   = filt_data_q;
  assign out_de      = out_de_q;
  assign out_data    = out_data_q;
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign out_sof     = out_sof_q;
  assign out_eof     = out_eof_q;
  assign out_border  = out_border_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Directed bench for median_frame_ctrl on a 4x3 frame; the filter is stood in
// for by a SKIP-beat line delay plus 4 cycles of latency.
module tb_median_frame_ctrl;
  localparam int U_COL = 4;
  localparam int U_ROW = 3;
  localparam int SKIP  = 5;
  localparam int NPIX  = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        border_zero = 1'b0;
  logic        in_de = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        filt_de;
  logic [7:0]  filt_data;
  logic        filt_out_de;
  logic [7:0]  filt_out_data;
  logic        out_de;
  logic [7:0]  out_data;
  logic [10:0] out_x;
  logic [9:0]  out_y;
  logic        out_sof, out_eof, out_border, busy, err_overrun;

  median_frame_ctrl #(.U_COL(U_COL), .U_ROW(U_ROW), .SKIP(SKIP)) dut (
    .clk(clk), .rst(rst), .start(start), .border_zero(border_zero),
    .in_de(in_de), .in_data(in_data),
    .filt_de(filt_de), .filt_data(filt_data),
    .filt_out_de(filt_out_de), .filt_out_data(filt_out_data),
    .out_de(out_de), .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .out_sof(out_sof), .out_eof(out_eof), .out_border(out_border),
    .busy(busy), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Filter stand-in: output beat n carries input beat n-SKIP, 4 cycles later.
  logic [7:0] sr   [SKIP] = '{default: 8'd0};
  logic       dde  [4]    = '{default: 1'b0};
  logic [7:0] ddat [4]    = '{default: 8'd0};
  always @(posedge clk) begin
    if (filt_de) begin
      for (int i = SKIP - 1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= filt_data;
    end
    dde[0]  <= filt_de;
    ddat[0] <= sr[SKIP-1];
    for (int i = 1; i < 4; i++) begin
      dde[i]  <= dde[i-1];
      ddat[i] <= ddat[i-1];
    end
  end
  assign filt_out_de   = dde[3];
  assign filt_out_data = ddat[3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_out = 0, n_filt = 0, n_eof = 0, eof_cyc = -1;
  logic [7:0] o_dat [512];
  int         o_x [512], o_y [512], o_sof [512], o_eof [512], o_brd [512];
  logic [7:0] f_dat [512];
  always @(negedge clk) begin
    if (out_de && n_out < 512) begin
      o_dat[n_out] = out_data;
      o_x[n_out]   = int'(out_x);
      o_y[n_out]   = int'(out_y);
      o_sof[n_out] = int'(out_sof);
      o_eof[n_out] = int'(out_eof);
      o_brd[n_out] = int'(out_border);
      n_out++;
      if (out_eof) begin
        n_eof++;
        eof_cyc = cyc;
      end
    end
    if (filt_de && n_filt < 512) begin
      f_dat[n_filt] = filt_data;
      n_filt++;
    end
  end

  int checks = 0;
  int failures = 0;
  int idle_cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic bz);
    @(posedge clk); #1;
    start = 1'b1;
    border_zero = bz;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int gap, input int cv, input int n, input int mid_start);
    for (int i = 0; i < n; i++) begin
      in_de   = 1'b1;
      in_data = (cv != 0) ? 8'(cv) : 8'(i + 1);
      start   = (mid_start != 0 && i == 6);
      @(posedge clk); #1;
      in_de = 1'b0;
      start = 1'b0;
      if (gap != 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    idle_cyc = cyc;
    chk("busy_fall_timeout", int'(k < 300), 1);
    #1;
  endtask

  task automatic check_frame(input string nm, input int base, input logic bz, input int cv);
    int x, y, brd, d;
    chk({nm, "_count"}, n_out - base, NPIX);
    for (int k = 0; k < NPIX; k++) begin
      x = k % U_COL;
      y = k / U_COL;
      brd = int'(x == 0 || x == U_COL - 1 || y == 0 || y == U_ROW - 1);
      d = (cv != 0) ? cv : k + 1;
      if (bz && brd != 0) d = 0;
      chk($sformatf("%s_x%0d", nm, k), o_x[(base + k) % 512], x);
      chk($sformatf("%s_y%0d", nm, k), o_y[(base + k) % 512], y);
      chk($sformatf("%s_data%0d", nm, k), int'(o_dat[(base + k) % 512]), d);
      chk($sformatf("%s_sof%0d", nm, k), o_sof[(base + k) % 512], int'(k == 0));
      chk($sformatf("%s_eof%0d", nm, k), o_eof[(base + k) % 512], int'(k == NPIX - 1));
      chk($sformatf("%s_brd%0d", nm, k), o_brd[(base + k) % 512], brd);
    end
    chk({nm, "_busy_after_eof"}, idle_cyc, eof_cyc + 1);
  endtask

  task automatic check_filt(input string nm, input int fbase);
    chk({nm, "_filt_count"}, n_filt - fbase, NPIX + SKIP);
    for (int i = 0; i < NPIX + SKIP; i++)
      chk($sformatf("%s_filt%0d", nm, i), int'(f_dat[(fbase + i) % 512]),
          (i < NPIX) ? i + 1 : 0);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_out_de"}, int'(out_de), 0);
    chk({nm, "_out_data"}, int'(out_data), 0);
    chk({nm, "_out_x"}, int'(out_x), 0);
    chk({nm, "_out_y"}, int'(out_y), 0);
    chk({nm, "_out_sof"}, int'(out_sof), 0);
    chk({nm, "_out_eof"}, int'(out_eof), 0);
    chk({nm, "_out_border"}, int'(out_border), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_err"}, int'(err_overrun), 0);
    chk({nm, "_filt_de"}, int'(filt_de), 0);
    chk({nm, "_filt_data"}, int'(filt_data), 0);
  endtask

  initial begin
    int ob, fb, eb;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // contiguous frame 1..12
    ob = n_out; fb = n_filt;
    do_start(1'b0);
    chk("t1_busy_rise", int'(busy), 1);
    feed(0, 0, NPIX, 0);
    wait_idle();
    check_frame("t1", ob, 1'b0, 0);
    check_filt("t1", fb);
    chk("t1_err", int'(err_overrun), 0);

    // in_de every other cycle
    ob = n_out; fb = n_filt;
    do_start(1'b0);
    feed(1, 0, NPIX, 0);
    wait_idle();
    check_frame("t2", ob, 1'b0, 0);
    check_filt("t2", fb);

    // border zeroing with flat 200 input
    ob = n_out;
    do_start(1'b1);
    feed(0, 200, NPIX, 0);
    wait_idle();
    check_frame("t3", ob, 1'b1, 200);

    // overrun during FLUSH
    ob = n_out; fb = n_filt;
    do_start(1'b0);
    feed(0, 0, NPIX, 0);
    feed(0, 99, 3, 0);
    wait_idle();
    check_frame("t4", ob, 1'b0, 0);
    check_filt("t4", fb);
    chk("t4_err_set", int'(err_overrun), 1);

    // start while ACTIVE is ignored; new start clears err
    ob = n_out; fb = n_filt;
    do_start(1'b0);
    chk("t5_err_cleared", int'(err_overrun), 0);
    feed(0, 0, NPIX, 1);
    wait_idle();
    check_frame("t5", ob, 1'b0, 0);
    check_filt("t5", fb);

    // mid-frame reset then a clean frame
    eb = n_eof;
    do_start(1'b0);
    feed(0, 0, 6, 0);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("t6_abort");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t6_no_eof", n_eof, eb);
    chk("t6_idle", int'(busy), 0);
    ob = n_out; fb = n_filt;
    do_start(1'b0);
    feed(0, 0, NPIX, 0);
    wait_idle();
    check_frame("t6", ob, 1'b0, 0);
    check_filt("t6", fb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/median_frame_ctrl.md
# median_frame_ctrl

Frame sequencer that wraps the 3x3 median filter stage of the face-detection pipeline. It admits exactly one COL x ROW frame of pixels into the filter. It then injects flush beats so the line-buffer tail drains, discards the filter's leading alignment beats, and re-emits a frame-aligned pixel stream with x/y coordinates, border flag, and SOF/EOF markers.

## Interface
- U_COL, 1280, pixels per line (≥ 3)
- U_ROW, 720, lines per frame (≥ 3)
- SKIP, U_COL+1, leading filter output beats to discard; this equals the number of flush beats injected
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle frame arm request; honoured only in IDLE
- border_zero  in  1  1: border pixels forced to 0; 0: filter value passed through; sampled on start
- in_de  in  1  source pixel valid
- in_data  in  8  source pixel
- filt_de  out  1  pixel valid to median filter
- filt_data  out  8  pixel to median filter
- filt_out_de  in  1  median filter output valid
- filt_out_data  in  8  median filter output pixel
- out_de  out  1  aligned output valid
- out_data  out  8  aligned output pixel
- out_x  out  11  column of current output pixel
- out_y  out  10  row of current output pixel
- out_sof  out  1  high with out_de for pixel (0,0)
- out_eof  out  1  high with out_de for pixel (U_COL-1,U_ROW-1)
- out_border  out  1  high with out_de when x∈{0,U_COL-1} or y∈{0,U_ROW-1}
- busy  out  1  high in every state except IDLE
- err_overrun  out  1  sticky; set when an in_de beat is dropped; cleared on accepted start

## Operation
- The state machine has four states: IDLE, ACTIVE, FLUSH, DRAIN.
- IDLE: in_de is ignored and filt_de is 0. When start is high, latch border_zero, clear the counters and err_overrun, and go to ACTIVE.
- ACTIVE: each in_de beat is forwarded as filt_de/filt_data, and in_cnt is incremented. On the beat where in_cnt reaches U_COL*U_ROW, go to FLUSH.
- FLUSH: drive filt_de=1 and filt_data=0 every cycle for SKIP cycles, counted by flush_cnt, then go to DRAIN.
  - in_de in this state is dropped and sets err_overrun.
- DRAIN: wait until out_cnt reaches U_COL*U_ROW, then go to IDLE.
  - in_de in this state is dropped and sets err_overrun.
- Output side, active in all non-IDLE states:
  - Each filt_out_de beat increments beat_cnt.
  - Beats with beat_cnt < SKIP are discarded.
  - Later beats are emitted on out_de, with out_x/out_y taken from a column counter that wraps at U_COL-1 and increments the row.
  - out_cnt counts emitted beats.
- Border: when the latched border_zero is 1 and the pixel is a border pixel, out_data=0; otherwise out_data=filt_out_data. out_border is flagged regardless of mode.
- filt_out_de beats in IDLE, or beats beyond U_COL*U_ROW emitted pixels, are ignored.
- start while busy is ignored. in_de and start in the same IDLE cycle: that beat is dropped (without setting err).
- Counter widths: in_cnt and out_cnt are sized by $clog2(U_COL*U_ROW+1); flush_cnt and beat_cnt by $clog2(SKIP+1).

## Timing
- Reset values: all outputs 0; out_x=0 and out_y=0; state IDLE.
- filt_de/filt_data are registered, 1 cycle after in_de.
- FLUSH begins the cycle after the last accepted beat's filt_de, giving a continuous stream with no bubble.
- All out_* signals are registered, 1 cycle after filt_out_de. The filter itself adds 4 cycles from filt_de.
- busy rises the cycle after start and falls the cycle after the out_eof beat.
- out_sof and out_eof are single-cycle and coincide with out_de.
- rst mid-frame aborts immediately. Outputs return to their reset values and no partial EOF is issued. The filter may still emit stale beats; these are ignored in IDLE.

## Test plan
- U_COL=4, U_ROW=3, SKIP=5; start, then 12 consecutive beats with values 1..12 → exactly 12 filt_de beats of data plus 5 flush zeros.
  - out_de ×12 with x/y in raster order.
  - out_sof on (0,0); out_eof on (3,2).
  - busy falls 1 cycle after out_eof.
- Same frame with in_de toggling every other cycle → identical out_data/x/y sequence, and no flush beat before the 12th input.
- border_zero=1 with all inputs 200 → 10 border outputs are 0 and 2 interior outputs (1,1),(2,1) are 200; out_border matches.
- 3 extra in_de beats after the 12th, during FLUSH → beats dropped, err_overrun=1, output stream unchanged; the next start clears err_overrun.
- start pulsed during ACTIVE → ignored, counters undisturbed; out_eof still at beat 12.
- rst asserted after 6 input beats → all outputs 0 the next cycle, busy=0, no out_eof. A fresh start then produces a correct full frame.
